// File: rtl/lsu_mem_sequencer_if.sv
// LSU request/response channel plus single-port dmem beat bus.
// slave: sequencer side; master: LSU + memory side.
interface lsu_mem_sequencer_if #(
  parameter int AW = 9
);
  logic          i_req_valid;
  logic          o_req_ready;
  logic [31:0]   i_req_addr;
  logic [1:0]    i_req_size;
  logic          i_req_signed;
  logic          i_req_wren;
  logic [31:0]   i_req_wdata;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [31:0]   o_rsp_rdata;
  logic          o_rsp_err;
  logic          o_mem_en;
  logic          o_mem_wren;
  logic [AW-1:0] o_mem_addr;
  logic [3:0]    o_mem_bmask;
  logic [31:0]   o_mem_wdata;
  logic [31:0]   i_mem_rdata;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_size,
    input  i_req_signed, i_req_wren, i_req_wdata,
    input  i_rsp_ready, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata,
    output o_rsp_err, o_mem_en, o_mem_wren,
    output o_mem_addr, o_mem_bmask, o_mem_wdata
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_size,
    output i_req_signed, i_req_wren, i_req_wdata,
    output i_rsp_ready, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata,
    input  o_rsp_err, o_mem_en, o_mem_wren,
    input  o_mem_addr, o_mem_bmask, o_mem_wdata
  );
endinterface

// File: rtl/lsu_mem_sequencer.sv
// Sequences LSU loads/stores onto a byte-masked 1-cycle dmem,
// splitting misaligned accesses into two beats. Ports: i_clk, i_reset_n, bus.
module lsu_mem_sequencer #(
  parameter int MEM_WORDS = 512,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input logic i_clk,
  input logic i_reset_n,
  lsu_mem_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, BEAT0, BEAT1, CAPT, RESP
  } state_e;

  state_e        state_q;
  logic          ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rdata_q;
  logic          mem_en_q;
  logic          mem_wren_q;
  logic [AW-1:0] mem_addr_q;
  logic [3:0]    mem_bmask_q;
  logic [31:0]   mem_wdata_q;

  logic [AW-1:0] word_q;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic          wren_q;
  logic          split_q;
  logic [3:0]    b1_mask_q;
  logic [31:0]   b1_data_q;
  logic [31:0]   lo_q;

  logic          accept;
  logic [1:0]    off_d;
  logic [2:0]    nbytes;
  logic          split_d;
  logic [32:0]   last;
  logic          err_d;
  logic [3:0]    base;
  logic [63:0]   wd;
  logic [7:0]    bm;
  logic [31:0]   lo;
  logic [31:0]   hi;
  logic [31:0]   raw;
  logic [31:0]   ext;

  assign accept = bus.i_req_valid & ready_q;
  assign off_d  = bus.i_req_addr[1:0];

  always_comb begin
    nbytes = 3'd4;
    base   = 4'b1111;
    unique case (1'b1)
      bus.i_req_size == 2'b00: begin
        nbytes = 3'd1;
        base   = 4'b0001;
      end
      bus.i_req_size == 2'b01: begin
        nbytes = 3'd2;
        base   = 4'b0011;
      end
      default: begin
        nbytes = 3'd4;
        base   = 4'b1111;
      end
    endcase
  end

  // 33-bit end address so requests near 2^32 cannot wrap into range
  assign split_d = ({1'b0, off_d} + nbytes) > 3'd4;
  assign last    = {1'b0, bus.i_req_addr}
                 + {30'b0, nbytes} - 33'd1;
  assign err_d   = (bus.i_req_size == 2'b11)
                 | (last >= 33'(4 * MEM_WORDS));
  assign wd      = {32'b0, bus.i_req_wdata} << {off_d, 3'b000};
  assign bm      = {4'b0, base} << off_d;

  // In CAPT the beat just read sits on i_mem_rdata
  always_comb begin
    lo  = split_q ? lo_q : bus.i_mem_rdata;
    hi  = split_q ? bus.i_mem_rdata : 32'b0;
    raw = 32'({hi, lo} >> {off_q, 3'b000});
    unique case (size_q)
      2'b00:   ext = {{24{sgn_q & raw[7]}}, raw[7:0]};
      2'b01:   ext = {{16{sgn_q & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_bmask_q <= '0;
      mem_wdata_q <= '0;
      word_q      <= '0;
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      wren_q      <= 1'b0;
      split_q     <= 1'b0;
      b1_mask_q   <= '0;
      b1_data_q   <= '0;
      lo_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            ready_q   <= 1'b0;
            word_q    <= bus.i_req_addr[AW+1:2];
            off_q     <= off_d;
            size_q    <= bus.i_req_size;
            sgn_q     <= bus.i_req_signed;
            wren_q    <= bus.i_req_wren;
            split_q   <= split_d;
            b1_mask_q <= bus.i_req_wren ? bm[7:4] : 4'b0;
            b1_data_q <= bus.i_req_wren ? wd[63:32] : 32'b0;
            rdata_q   <= '0;
            if (err_d) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              state_q     <= RESP;
            end else begin
              mem_en_q    <= 1'b1;
              mem_wren_q  <= bus.i_req_wren;
              mem_addr_q  <= bus.i_req_addr[AW+1:2];
              mem_bmask_q <= bus.i_req_wren ? bm[3:0] : 4'b0;
              mem_wdata_q <= bus.i_req_wren ? wd[31:0] : 32'b0;
              state_q     <= BEAT0;
            end
          end
        end
        BEAT0: begin
          if (split_q) begin
            mem_addr_q  <= word_q + 1'b1;
            mem_bmask_q <= b1_mask_q;
            mem_wdata_q <= b1_data_q;
            state_q     <= BEAT1;
          end else begin
            mem_en_q    <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_bmask_q <= '0;
            mem_wdata_q <= '0;
            if (wren_q) begin
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q     <= CAPT;
            end
          end
        end
        BEAT1: begin
          if (!wren_q) lo_q <= bus.i_mem_rdata;
          mem_en_q    <= 1'b0;
          mem_wren_q  <= 1'b0;
          mem_bmask_q <= '0;
          mem_wdata_q <= '0;
          if (wren_q) begin
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            state_q     <= CAPT;
          end
        end
        CAPT: begin
          rdata_q     <= ext;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = ready_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_rsp_rdata = rdata_q;
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_wren  = mem_wren_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_bmask = mem_bmask_q;
  assign bus.o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Bench for lsu_mem_sequencer: directed cases plus random
// accesses against a byte-array reference of memory.
module tb_lsu_mem_sequencer;
  localparam int AW = 9;
  localparam int MW = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_sequencer_if #(.AW(AW)) bus ();

  lsu_mem_sequencer #(.MEM_WORDS(MW), .AW(AW)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0]   mem [MW];
  logic [7:0]    rm [4*MW];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;
  int            beat_cnt = 0;
  logic [AW-1:0] log_a [64];
  logic [3:0]    log_m [64];
  logic [31:0]   log_d [64];
  logic          log_w [64];

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.o_mem_en) begin
      log_a[beat_cnt[5:0]] <= bus.o_mem_addr;
      log_m[beat_cnt[5:0]] <= bus.o_mem_bmask;
      log_d[beat_cnt[5:0]] <= bus.o_mem_wdata;
      log_w[beat_cnt[5:0]] <= bus.o_mem_wren;
      if (bus.o_mem_wren)
        for (int b = 0; b < 4; b++)
          if (bus.o_mem_bmask[b])
            mem[bus.o_mem_addr][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
      bus.i_mem_rdata <= mem[bus.o_mem_addr];
      beat_cnt <= beat_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input int w, input logic [31:0] d);
    pl_we   = 1'b1;
    pl_addr = AW'(w);
    pl_data = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
    for (int b = 0; b < 4; b++) rm[4*w+b] = d[8*b +: 8];
  endtask

  // hold < 0 picks a random backpressure length
  task automatic txn(input logic [31:0] a, input logic [1:0] sz,
                     input bit sg, input bit wr,
                     input logic [31:0] wdat, input int hold,
                     output logic [31:0] rd, output logic er,
                     output int b0);
    int n, lat, exp_beats, exp_lat, h;
    longint lastb;
    bit err_e;
    logic [31:0] exp_d;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lastb = longint'(a) + n - 1;
    err_e = (sz == 2'd3) || (lastb >= 4 * MW);
    exp_beats = err_e ? 0 : ((int'(a % 4) + n > 4) ? 2 : 1);
    exp_lat = err_e ? 1 : 1 + exp_beats + (wr ? 0 : 1);
    exp_d = '0;
    if (!err_e && !wr) begin
      for (int i = n - 1; i >= 0; i--)
        exp_d = (exp_d << 8) | 32'(rm[int'(a) + i]);
      if (sg && exp_d[8*n-1])
        exp_d = exp_d | ~((32'd1 << (8*n)) - 32'd1);
    end
    check("req_ready_idle", 32'(bus.o_req_ready), 32'd1);
    bus.i_req_valid  = 1'b1;
    bus.i_req_addr   = a;
    bus.i_req_size   = sz;
    bus.i_req_signed = sg;
    bus.i_req_wren   = wr;
    bus.i_req_wdata  = wdat;
    b0 = beat_cnt;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    lat = 1;
    while (!bus.o_rsp_valid && lat < 12) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("beats", 32'(beat_cnt - b0), 32'(exp_beats));
    check("rdata", bus.o_rsp_rdata, exp_d);
    check("err", 32'(bus.o_rsp_err), 32'(err_e));
    rd = bus.o_rsp_rdata;
    er = bus.o_rsp_err;
    h = (hold < 0) ? int'($urandom_range(0, 2)) : hold;
    repeat (h) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(bus.o_rsp_valid), 32'd1);
      check("bp_rdata", bus.o_rsp_rdata, exp_d);
      check("bp_ready", 32'(bus.o_req_ready), 32'd0);
    end
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_rsp_ready = 1'b0;
    check("rsp_drop", 32'(bus.o_rsp_valid), 32'd0);
    if (!err_e && wr)
      for (int i = 0; i < n; i++) rm[int'(a) + i] = wdat[8*i +: 8];
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int b0;
    logic [31:0] a;
    bus.i_req_valid  = 1'b0;
    bus.i_req_addr   = '0;
    bus.i_req_size   = '0;
    bus.i_req_signed = 1'b0;
    bus.i_req_wren   = 1'b0;
    bus.i_req_wdata  = '0;
    bus.i_rsp_ready  = 1'b0;
    @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.o_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_mem_en", 32'(bus.o_mem_en), 32'd0);
    check("rst_rdata", bus.o_rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.o_rsp_err), 32'd0);
    check("rst_bmask", 32'(bus.o_mem_bmask), 32'd0);
    for (int w = 0; w < MW; w++) poke(w, $urandom);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    poke(4, 32'hDEADBEEF);
    txn(32'h010, 2'd2, 1'b0, 1'b0, 32'h0, 0, rd, er, b0);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_addr", 32'(log_a[b0[5:0]]), 32'd4);
    check("lw_mask", 32'(log_m[b0[5:0]]), 32'd0);
    check("lw_wren", 32'(log_w[b0[5:0]]), 32'd0);

    txn(32'h011, 2'd2, 1'b0, 1'b1, 32'hAABBCCDD, 0, rd, er, b0);
    check("sw_b0_addr", 32'(log_a[b0[5:0]]), 32'd4);
    check("sw_b0_mask", 32'(log_m[b0[5:0]]), 32'hE);
    check("sw_b0_data", log_d[b0[5:0]], 32'hBBCCDD00);
    b0++;
    check("sw_b1_addr", 32'(log_a[b0[5:0]]), 32'd5);
    check("sw_b1_mask", 32'(log_m[b0[5:0]]), 32'h1);
    check("sw_b1_data", log_d[b0[5:0]], 32'h000000AA);

    poke(4, 32'h80112233);
    poke(5, 32'h445566FF);
    txn(32'h013, 2'd1, 1'b1, 1'b0, 32'h0, 0, rd, er, b0);
    check("lh_split", rd, 32'hFFFFFF80);

    poke(1, 32'h00C30000);
    txn(32'h006, 2'd0, 1'b0, 1'b0, 32'h0, 0, rd, er, b0);
    check("lbu", rd, 32'h000000C3);
    txn(32'h006, 2'd0, 1'b1, 1'b0, 32'h0, 5, rd, er, b0);
    check("lb", rd, 32'hFFFFFFC3);

    txn(32'h7FE, 2'd2, 1'b0, 1'b1, 32'h11223344, 0, rd, er, b0);
    check("sw_oor_err", 32'(er), 32'd1);
    txn(32'h800, 2'd0, 1'b0, 1'b1, 32'h55, 0, rd, er, b0);
    check("sb_oor_err", 32'(er), 32'd1);
    txn(32'h7FF, 2'd0, 1'b0, 1'b0, 32'h0, 0, rd, er, b0);
    check("lb_last_ok", 32'(er), 32'd0);
    txn(32'hFFFF_FFFE, 2'd1, 1'b0, 1'b0, 32'h0, 0, rd, er, b0);
    txn(32'h020, 2'd3, 1'b0, 1'b0, 32'h0, 0, rd, er, b0);

    poke(4, 32'h0);
    poke(5, 32'h12345678);
    bus.i_req_valid  = 1'b1;
    bus.i_req_addr   = 32'h011;
    bus.i_req_size   = 2'd2;
    bus.i_req_signed = 1'b0;
    bus.i_req_wren   = 1'b1;
    bus.i_req_wdata  = 32'hAABBCCDD;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b1_en", 32'(bus.o_mem_en), 32'd1);
    check("b1_addr", 32'(bus.o_mem_addr), 32'd5);
    rst_n = 1'b0;
    #1;
    check("arst_mem_en", 32'(bus.o_mem_en), 32'd0);
    check("arst_rsp", 32'(bus.o_rsp_valid), 32'd0);
    check("arst_ready", 32'(bus.o_req_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rm[32'h11] = 8'hDD;
    rm[32'h12] = 8'hCC;
    rm[32'h13] = 8'hBB;
    check("word5_kept", mem[5], 32'h12345678);
    txn(32'h014, 2'd2, 1'b0, 1'b0, 32'h0, 0, rd, er, b0);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 15) == 0) a = $urandom_range(2040, 2100);
      else a = $urandom_range(0, 2047);
      txn(a, 2'($urandom_range(0, 3)), 1'($urandom),
          1'($urandom), $urandom, -1, rd, er, b0);
    end

    for (int w = 0; w < MW; w++)
      check($sformatf("mem[%0d]", w), mem[w],
            {rm[4*w+3], rm[4*w+2], rm[4*w+1], rm[4*w]});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
